uart_rx_frame_check: RTL and testbench

- Serial, per-bit frame checker for the UART RX path.
- Consumes each oversampled bit as the sampler produces it, and assembles data LSB-first.
- Accumulates parity on the fly for none, even, odd, mark or space parity.
- Checks one or two stop bits and reports per-frame parity and stop errors with a one-cycle done strobe.
- Sits between the RX data sampler and the RX FSM/output register. It replaces the single-shot parity-only check.

---
 rtl/urt_rx_pkg.sv | 35 +++
 rtl/uart_rx_frame_check_if.sv | 36 +++
 rtl/urt_rx_sat_cnt.sv | 30 +++
 rtl/uart_rx_frame_check.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_rx_frame_check.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/urt_rx_pkg.sv
// Shared definitions for the UART RX frame checker: parity-type codes,
// FSM state encoding, the minimum data length and the expected-parity helper.
package urt_rx_pkg;

    // Parity type codes as presented on PAR_TYP.
    localparam logic [1:0] PAR_EVEN  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_MARK  = 2'b10;
    localparam logic [1:0] PAR_SPACE = 2'b11;

    // Shortest frame the checker accepts; shorter DATA_LEN values are raised to this.
    localparam int unsigned MIN_DATA_LEN = 5;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop1,
        StStop2,
        StDone
    } frm_state_e;

    // Parity bit the line should carry, given the type and the XOR of the data bits.
    function automatic logic exp_par_bit(input logic [1:0] typ, input logic acc);
        logic exp_bit;
        case (typ)
            PAR_EVEN: exp_bit = acc;
            PAR_ODD:  exp_bit = ~acc;
            PAR_MARK: exp_bit = 1'b1;
            default:  exp_bit = 1'b0;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// Bus between the RX sampler/FSM side (master) and the frame checker (slave).
interface uart_rx_frame_check_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 5,
    parameter int unsigned CNT_WIDTH  = 8
);

    logic                  start_det;
    logic                  bit_valid;
    logic                  sampled_bit;
    logic                  PAR_EN;
    logic [1:0]            PAR_TYP;
    logic [LEN_WIDTH-1:0]  DATA_LEN;
    logic                  STP_2;
    logic                  cnt_clr;

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  frame_done;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;
    logic                  frm_abort;
    logic [CNT_WIDTH-1:0]  par_err_cnt;
    logic [CNT_WIDTH-1:0]  stp_err_cnt;

    modport master (
        output start_det, bit_valid, sampled_bit, PAR_EN, PAR_TYP, DATA_LEN, STP_2, cnt_clr,
        input  P_DATA, frame_done, par_err, stp_err, busy, frm_abort, par_err_cnt, stp_err_cnt
    );

    modport slave (
        input  start_det, bit_valid, sampled_bit, PAR_EN, PAR_TYP, DATA_LEN, STP_2, cnt_clr,
        output P_DATA, frame_done, par_err, stp_err, busy, frm_abort, par_err_cnt, stp_err_cnt
    );

endinterface

// File: rtl/urt_rx_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module urt_rx_sat_cnt #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 CLK_FRM_CHK,
    input  logic                 RST_FRM_CHK,
    input  logic                 clr,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    logic [CNT_WIDTH-1:0] cnt_q;

    // Count events, holding at all-ones.
    always_ff @(posedge CLK_FRM_CHK or negedge RST_FRM_CHK) begin
        if (!RST_FRM_CHK) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    // Drive the count port.
    always_comb begin
        cnt = cnt_q;
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// Per-bit UART RX frame checker: assembles data LSB-first, accumulates parity,
// checks one or two stop bits and reports per-frame errors with a done strobe.
// Optional error counters are built only when URT_RX_ERR_CNT_EN is defined.
module uart_rx_frame_check #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 5,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK_FRM_CHK,
    input  logic                  RST_FRM_CHK,
    uart_rx_frame_check_if.slave  frm
);

    import urt_rx_pkg::*;

    localparam logic [LEN_WIDTH-1:0] MinLen = LEN_WIDTH'(MIN_DATA_LEN);
    localparam logic [LEN_WIDTH-1:0] MaxLen = LEN_WIDTH'(DATA_WIDTH);

    frm_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [LEN_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  par_acc_q, par_acc_d;
    logic                  par_fail_q, par_fail_d;
    logic                  stp_fail_q, stp_fail_d;

    // Frame configuration captured at start_det.
    logic                  par_en_q, par_en_d;
    logic [1:0]            par_typ_q, par_typ_d;
    logic [LEN_WIDTH-1:0]  data_len_q, data_len_d;
    logic                  stp2_q, stp2_d;

    // Results presented to the consumer; they hold until the next completed frame.
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  abort_q, abort_d;
    logic                  out_load;

    logic [LEN_WIDTH-1:0]  len_clamped;
    logic                  last_data;
    logic                  frame_done;
    logic [CNT_WIDTH-1:0]  par_cnt;
    logic [CNT_WIDTH-1:0]  stp_cnt;

    // Clamp the requested data length into the supported range.
    always_comb begin
        if (frm.DATA_LEN < MinLen) begin
            len_clamped = MinLen;
        end else if (frm.DATA_LEN > MaxLen) begin
            len_clamped = MaxLen;
        end else begin
            len_clamped = frm.DATA_LEN;
        end
    end

    // State register.
    always_ff @(posedge CLK_FRM_CHK or negedge RST_FRM_CHK) begin
        if (!RST_FRM_CHK) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath update; start_det outranks everything, including a
    // coincident bit_valid.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_acc_d  = par_acc_q;
        par_fail_d = par_fail_q;
        stp_fail_d = stp_fail_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        data_len_d = data_len_q;
        stp2_d     = stp2_q;
        abort_d    = 1'b0;
        out_load   = 1'b0;
        last_data  = ((bit_cnt_q + LEN_WIDTH'(1)) == data_len_q);

        if (frm.start_det) begin
            abort_d    = (state_q != StIdle) && (state_q != StDone);
            state_d    = StData;
            shift_d    = '0;
            bit_cnt_d  = '0;
            par_acc_d  = 1'b0;
            par_fail_d = 1'b0;
            stp_fail_d = 1'b0;
            par_en_d   = frm.PAR_EN;
            par_typ_d  = frm.PAR_TYP;
            data_len_d = len_clamped;
            stp2_d     = frm.STP_2;
        end else if (state_q == StDone) begin
            state_d = StIdle;
        end else if (frm.bit_valid) begin
            unique case (state_q)
                StData: begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bit_cnt_q == LEN_WIDTH'(i)) begin
                            shift_d[i] = frm.sampled_bit;
                        end
                    end
                    par_acc_d = par_acc_q ^ frm.sampled_bit;
                    bit_cnt_d = bit_cnt_q + LEN_WIDTH'(1);
                    if (last_data) begin
                        state_d = par_en_q ? StParity : StStop1;
                    end
                end
                StParity: begin
                    if (frm.sampled_bit != exp_par_bit(par_typ_q, par_acc_q)) begin
                        par_fail_d = 1'b1;
                    end
                    state_d = StStop1;
                end
                StStop1: begin
                    if (!frm.sampled_bit) begin
                        stp_fail_d = 1'b1;
                    end
                    if (stp2_q) begin
                        state_d = StStop2;
                    end else begin
                        state_d  = StDone;
                        out_load = 1'b1;
                    end
                end
                StStop2: begin
                    if (!frm.sampled_bit) begin
                        stp_fail_d = 1'b1;
                    end
                    state_d  = StDone;
                    out_load = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath and result registers; results load on the last stop bit so they
    // are already valid during the frame_done cycle.
    always_ff @(posedge CLK_FRM_CHK or negedge RST_FRM_CHK) begin
        if (!RST_FRM_CHK) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            par_acc_q  <= 1'b0;
            par_fail_q <= 1'b0;
            stp_fail_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= PAR_EVEN;
            data_len_q <= '0;
            stp2_q     <= 1'b0;
            p_data_q   <= '0;
            par_err_q  <= 1'b0;
            stp_err_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            par_acc_q  <= par_acc_d;
            par_fail_q <= par_fail_d;
            stp_fail_q <= stp_fail_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            data_len_q <= data_len_d;
            stp2_q     <= stp2_d;
            abort_q    <= abort_d;
            if (out_load) begin
                p_data_q  <= shift_d;
                par_err_q <= par_fail_d;
                stp_err_q <= stp_fail_d;
            end
        end
    end

    // Decode state into the status outputs and present the result registers.
    always_comb begin
        frame_done      = (state_q == StDone);
        frm.frame_done  = frame_done;
        frm.busy        = (state_q != StIdle) && (state_q != StDone);
        frm.frm_abort   = abort_q;
        frm.P_DATA      = p_data_q;
        frm.par_err     = par_err_q;
        frm.stp_err     = stp_err_q;
        frm.par_err_cnt = par_cnt;
        frm.stp_err_cnt = stp_cnt;
    end

`ifdef URT_RX_ERR_CNT_EN
    logic par_inc;
    logic stp_inc;

    // Count each completed frame's errors once, in its done cycle.
    always_comb begin
        par_inc = frame_done & par_err_q;
        stp_inc = frame_done & stp_err_q;
    end

    urt_rx_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_par_cnt (
        .CLK_FRM_CHK (CLK_FRM_CHK),
        .RST_FRM_CHK (RST_FRM_CHK),
        .clr         (frm.cnt_clr),
        .inc         (par_inc),
        .cnt         (par_cnt)
    );

    urt_rx_sat_cnt #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_stp_cnt (
        .CLK_FRM_CHK (CLK_FRM_CHK),
        .RST_FRM_CHK (RST_FRM_CHK),
        .clr         (frm.cnt_clr),
        .inc         (stp_inc),
        .cnt         (stp_cnt)
    );
`else
    logic unused_cnt_clr;

    // Counters absent: ports read as zero and the clear input has no effect.
    always_comb begin
        par_cnt        = '0;
        stp_cnt        = '0;
        unused_cnt_clr = frm.cnt_clr;
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Directed bench for uart_rx_frame_check; counter expectations follow URT_RX_ERR_CNT_EN.
module tb_uart_rx_frame_check;

    localparam int unsigned DW = 8;
    localparam int unsigned LW = 5;
    localparam int unsigned CW = 8;

`ifdef URT_RX_ERR_CNT_EN
    localparam bit CntOn = 1'b1;
`else
    localparam bit CntOn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_rx_frame_check_if #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW)
    ) frm ();

    uart_rx_frame_check #(
        .DATA_WIDTH (DW),
        .LEN_WIDTH  (LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK_FRM_CHK (clk),
        .RST_FRM_CHK (rst_n),
        .frm         (frm)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int exp_par_cnt = 0;
    int exp_stp_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cfg(input logic pe, input logic [1:0] pt, input logic [4:0] len,
                           input logic s2);
        frm.PAR_EN   = pe;
        frm.PAR_TYP  = pt;
        frm.DATA_LEN = len;
        frm.STP_2    = s2;
    endtask

    // Start a frame, then disturb the config inputs, which must be ignored.
    task automatic pulse_start();
        frm.start_det = 1'b1;
        @(posedge clk); #1;
        frm.start_det = 1'b0;
        frm.PAR_EN    = ~frm.PAR_EN;
        frm.PAR_TYP   = ~frm.PAR_TYP;
        frm.DATA_LEN  = 5'd6;
        frm.STP_2     = ~frm.STP_2;
    endtask

    // One idle cycle, then a one-cycle bit strobe; returns 1 time unit after it is taken.
    task automatic send_bit(input logic b);
        @(posedge clk); #1;
        frm.bit_valid   = 1'b1;
        frm.sampled_bit = b;
        @(posedge clk); #1;
        frm.bit_valid   = 1'b0;
        frm.sampled_bit = 1'b0;
    endtask

    task automatic send_data(input logic [15:0] d, input int n);
        logic [15:0] v;
        v = d;
        for (int i = 0; i < n; i++) begin
            send_bit(v[i]);
        end
    endtask

    // Called in the cycle right after the last stop strobe.
    task automatic check_done(input string tag, input logic [7:0] exp_data,
                              input logic exp_par, input logic exp_stp);
        check_eq({tag, ".frame_done"}, 32'(frm.frame_done), 32'd1);
        check_eq({tag, ".P_DATA"}, 32'(frm.P_DATA), 32'(exp_data));
        check_eq({tag, ".par_err"}, 32'(frm.par_err), 32'(exp_par));
        check_eq({tag, ".stp_err"}, 32'(frm.stp_err), 32'(exp_stp));
        check_eq({tag, ".busy"}, 32'(frm.busy), 32'd0);
        if (CntOn) begin
            if (exp_par && exp_par_cnt < 255) exp_par_cnt++;
            if (exp_stp && exp_stp_cnt < 255) exp_stp_cnt++;
        end
        @(posedge clk); #1;
        check_eq({tag, ".done_low"}, 32'(frm.frame_done), 32'd0);
        check_eq({tag, ".hold"}, 32'(frm.P_DATA), 32'(exp_data));
        check_eq({tag, ".par_cnt"}, 32'(frm.par_err_cnt), 32'(exp_par_cnt));
        check_eq({tag, ".stp_cnt"}, 32'(frm.stp_err_cnt), 32'(exp_stp_cnt));
    endtask

    task automatic run_frame(input string tag, input logic pe, input logic [1:0] pt,
                             input logic [4:0] len, input logic s2, input logic [15:0] data,
                             input int n, input logic pbit, input logic st1, input logic st2,
                             input logic [7:0] exp_data, input logic exp_par,
                             input logic exp_stp);
        set_cfg(pe, pt, len, s2);
        pulse_start();
        send_data(data, n);
        if (pe) send_bit(pbit);
        send_bit(st1);
        if (s2) begin
            check_eq({tag, ".no_done_before_stop2"}, 32'(frm.frame_done), 32'd0);
            send_bit(st2);
        end
        check_done(tag, exp_data, exp_par, exp_stp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        frm.start_det   = 1'b0;
        frm.bit_valid   = 1'b0;
        frm.sampled_bit = 1'b0;
        frm.cnt_clr     = 1'b0;
        set_cfg(1'b0, 2'b00, 5'd8, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.frame_done", 32'(frm.frame_done), 32'd0);
        check_eq("rst.busy", 32'(frm.busy), 32'd0);
        check_eq("rst.P_DATA", 32'(frm.P_DATA), 32'd0);
        check_eq("rst.par_err", 32'(frm.par_err), 32'd0);
        check_eq("rst.stp_err", 32'(frm.stp_err), 32'd0);
        check_eq("rst.frm_abort", 32'(frm.frm_abort), 32'd0);
        check_eq("rst.par_cnt", 32'(frm.par_err_cnt), 32'd0);
        check_eq("rst.stp_cnt", 32'(frm.stp_err_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Data bits ignored while idle.
        send_bit(1'b1);
        check_eq("idle.busy", 32'(frm.busy), 32'd0);

        run_frame("8n1",     1'b0, 2'b00, 5'd8,  1'b0, 16'hA5, 8, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        run_frame("8e1_bad", 1'b1, 2'b00, 5'd8,  1'b0, 16'h07, 8, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0);
        run_frame("8e1_ok",  1'b1, 2'b00, 5'd8,  1'b0, 16'h07, 8, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
        run_frame("8o1",     1'b1, 2'b01, 5'd8,  1'b0, 16'h07, 8, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0);
        run_frame("7m1",     1'b1, 2'b10, 5'd7,  1'b0, 16'hFF, 7, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0);
        run_frame("7s1",     1'b1, 2'b11, 5'd7,  1'b0, 16'hFF, 7, 1'b0, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0);
        run_frame("8n1_stp", 1'b0, 2'b00, 5'd8,  1'b0, 16'h12, 8, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b1);
        run_frame("8n2_bad", 1'b0, 2'b00, 5'd8,  1'b1, 16'h81, 8, 1'b0, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);
        run_frame("8n2_ok",  1'b0, 2'b00, 5'd8,  1'b1, 16'h81, 8, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0);
        run_frame("len3",    1'b0, 2'b00, 5'd3,  1'b0, 16'h0D, 5, 1'b0, 1'b1, 1'b1, 8'h0D, 1'b0, 1'b0);
        run_frame("len20",   1'b0, 2'b00, 5'd20, 1'b0, 16'h5A, 8, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);

        // Abort after 4 data bits; the restart carries a coincident bit_valid that must be dropped.
        set_cfg(1'b0, 2'b00, 5'd8, 1'b0);
        pulse_start();
        send_data(16'h000F, 4);
        set_cfg(1'b0, 2'b00, 5'd8, 1'b0);
        frm.start_det   = 1'b1;
        frm.bit_valid   = 1'b1;
        frm.sampled_bit = 1'b1;
        @(posedge clk); #1;
        frm.start_det   = 1'b0;
        frm.bit_valid   = 1'b0;
        frm.sampled_bit = 1'b0;
        check_eq("abort.pulse", 32'(frm.frm_abort), 32'd1);
        check_eq("abort.busy", 32'(frm.busy), 32'd1);
        check_eq("abort.no_done", 32'(frm.frame_done), 32'd0);
        @(posedge clk); #1;
        check_eq("abort.pulse_low", 32'(frm.frm_abort), 32'd0);
        send_data(16'h3C, 8);
        send_bit(1'b1);
        check_done("abort_next", 8'h3C, 1'b0, 1'b0);

        // start_det during DONE: done still fires, new frame follows without abort.
        set_cfg(1'b0, 2'b00, 5'd8, 1'b0);
        pulse_start();
        send_data(16'h96, 8);
        send_bit(1'b1);
        set_cfg(1'b0, 2'b00, 5'd8, 1'b0);
        frm.start_det = 1'b1;
        #1;
        check_eq("done_start.frame_done", 32'(frm.frame_done), 32'd1);
        check_eq("done_start.P_DATA", 32'(frm.P_DATA), 32'h96);
        @(posedge clk); #1;
        frm.start_det = 1'b0;
        check_eq("done_start.no_abort", 32'(frm.frm_abort), 32'd0);
        check_eq("done_start.busy", 32'(frm.busy), 32'd1);
        send_data(16'h69, 8);
        send_bit(1'b1);
        check_done("after_done_start", 8'h69, 1'b0, 1'b0);

        // Saturation: 300 parity-error frames (even parity, zero data, parity bit 1).
        for (int k = 0; k < 300; k++) begin
            run_frame("sat", 1'b1, 2'b00, 5'd5, 1'b0, 16'h00, 5, 1'b1, 1'b1, 1'b1,
                      8'h00, 1'b1, 1'b0);
        end
        check_eq("sat.par_cnt", 32'(frm.par_err_cnt), CntOn ? 32'd255 : 32'd0);

        // cnt_clr in the done cycle of an error frame wins over the increment.
        set_cfg(1'b1, 2'b00, 5'd5, 1'b0);
        pulse_start();
        send_data(16'h00, 5);
        send_bit(1'b1);
        send_bit(1'b0);
        check_eq("clr.par_err", 32'(frm.par_err), 32'd1);
        check_eq("clr.stp_err", 32'(frm.stp_err), 32'd1);
        frm.cnt_clr = 1'b1;
        @(posedge clk); #1;
        frm.cnt_clr = 1'b0;
        exp_par_cnt = 0;
        exp_stp_cnt = 0;
        check_eq("clr.par_cnt", 32'(frm.par_err_cnt), 32'd0);
        check_eq("clr.stp_cnt", 32'(frm.stp_err_cnt), 32'd0);
        run_frame("post_clr", 1'b1, 2'b00, 5'd5, 1'b0, 16'h1F, 5, 1'b0, 1'b0, 1'b1,
                  8'h1F, 1'b1, 1'b1);

        // Reset mid-frame clears everything and the frame never completes.
        set_cfg(1'b0, 2'b00, 5'd8, 1'b0);
        pulse_start();
        send_data(16'hFF, 3);
        rst_n = 1'b0;
        #2;
        check_eq("mid_rst.busy", 32'(frm.busy), 32'd0);
        check_eq("mid_rst.P_DATA", 32'(frm.P_DATA), 32'd0);
        check_eq("mid_rst.par_err", 32'(frm.par_err), 32'd0);
        check_eq("mid_rst.stp_err", 32'(frm.stp_err), 32'd0);
        check_eq("mid_rst.par_cnt", 32'(frm.par_err_cnt), 32'd0);
        check_eq("mid_rst.stp_cnt", 32'(frm.stp_err_cnt), 32'd0);
        exp_par_cnt = 0;
        exp_stp_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_data(16'hFF, 5);
        send_bit(1'b1);
        check_eq("mid_rst.no_done", 32'(frm.frame_done), 32'd0);
        check_eq("mid_rst.idle", 32'(frm.busy), 32'd0);
        run_frame("post_rst", 1'b0, 2'b00, 5'd8, 1'b0, 16'hC3, 8, 1'b0, 1'b1, 1'b1,
                  8'hC3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
